// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker: assembles 3-byte movement packets and keeps an
// absolute, screen-clamped cursor position plus button state, all registered.
module ps2_mouse_tracker #(
  parameter int X_MAX   = 799,
  parameter int Y_MAX   = 599,
  parameter int X_INIT  = 400,
  parameter int Y_INIT  = 300,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        pkt_done,
  output logic        sync_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic signed [13:0] X_MAX_S  = 14'(X_MAX);
  localparam logic signed [13:0] Y_MAX_S  = 14'(Y_MAX);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [5:0]         b0_r;  // {y_ovf, x_ovf, y_sgn, x_sgn, R, L}
  logic [7:0]         b1_r;
  logic               upd_r;
  logic [1:0]         pkt_btn_r;
  logic signed [13:0] pkt_dx_r, pkt_dy_r;
  logic [11:0]        xpos_r, ypos_r;
  logic               left_r, right_r, pkt_done_r, sync_err_r;
  logic               store_b0_s, store_b1_s, store_b2_s, bad_sync_s, timeout_s;
  logic signed [13:0] nx_s, ny_s;
  logic               unused_s;

  assign unused_s = rx_data[2];

  // Overflowed axes contribute no movement; otherwise {sign, magnitude} is the delta.
  function automatic logic signed [13:0] delta(input logic ovf, input logic sgn,
                                               input logic [7:0] mag);
    if (ovf) return 14'sd0;
    else     return $signed({{6{sgn}}, mag});
  endfunction

  function automatic logic [11:0] clamp(input logic signed [13:0] v,
                                        input logic signed [13:0] max_v);
    if (v < 14'sd0)      return 12'd0;
    else if (v > max_v)  return 12'(max_v);
    else                 return v[11:0];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= WAIT_B0;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_B0: begin
        if (store_b0_s) state_s = WAIT_B1;
        else            state_s = WAIT_B0;
      end
      WAIT_B1: begin
        if (store_b1_s)     state_s = WAIT_B2;
        else if (timeout_s) state_s = WAIT_B0;
        else                state_s = WAIT_B1;
      end
      WAIT_B2: begin
        if (store_b2_s || timeout_s) state_s = WAIT_B0;
        else                         state_s = WAIT_B2;
      end
      default: state_s = WAIT_B0;
    endcase
  end

  // Per-state strobes; an arriving byte takes priority over a coincident timeout
  always_comb begin
    store_b0_s = 1'b0;
    store_b1_s = 1'b0;
    store_b2_s = 1'b0;
    bad_sync_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      WAIT_B0: begin
        if (rx_valid) begin
          if (rx_data[3]) store_b0_s = 1'b1;
          else            bad_sync_s = 1'b1;
        end else begin
          store_b0_s = 1'b0;
        end
      end
      WAIT_B1: begin
        if (rx_valid)               store_b1_s = 1'b1;
        else if (cnt_r == CNT_LAST) timeout_s  = 1'b1;
        else                        timeout_s  = 1'b0;
      end
      WAIT_B2: begin
        if (rx_valid)               store_b2_s = 1'b1;
        else if (cnt_r == CNT_LAST) timeout_s  = 1'b1;
        else                        timeout_s  = 1'b0;
      end
      default: timeout_s = 1'b0;
    endcase
  end

  // Inter-byte idle counter
  always_ff @(posedge clk) begin
    if (rst)                                              cnt_r <= '0;
    else if (state_r == WAIT_B0 || rx_valid || timeout_s) cnt_r <= '0;
    else                                                  cnt_r <= cnt_r + CW'(1);
  end

  // Packet assembly; the completed packet is copied out so a new byte 0 can land immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_r      <= 6'd0;
      b1_r      <= 8'd0;
      upd_r     <= 1'b0;
      pkt_btn_r <= 2'd0;
      pkt_dx_r  <= 14'sd0;
      pkt_dy_r  <= 14'sd0;
    end else begin
      if (store_b0_s) b0_r <= {rx_data[7:4], rx_data[1:0]};
      if (store_b1_s) b1_r <= rx_data;
      upd_r <= store_b2_s;
      if (store_b2_s) begin
        pkt_btn_r <= b0_r[1:0];
        pkt_dx_r  <= delta(b0_r[4], b0_r[2], b1_r);
        pkt_dy_r  <= delta(b0_r[5], b0_r[3], rx_data);
      end
    end
  end

  // PS/2 +Y is up while screen +Y is down, hence the subtraction
  always_comb begin
    nx_s = $signed({2'b00, xpos_r}) + pkt_dx_r;
    ny_s = $signed({2'b00, ypos_r}) - pkt_dy_r;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_r     <= 12'(X_INIT);
      ypos_r     <= 12'(Y_INIT);
      left_r     <= 1'b0;
      right_r    <= 1'b0;
      pkt_done_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      if (upd_r) begin
        xpos_r  <= clamp(nx_s, X_MAX_S);
        ypos_r  <= clamp(ny_s, Y_MAX_S);
        left_r  <= pkt_btn_r[0];
        right_r <= pkt_btn_r[1];
      end
      pkt_done_r <= upd_r;
      sync_err_r <= bad_sync_s | timeout_s;
    end
  end

  assign xpos     = xpos_r;
  assign ypos     = ypos_r;
  assign left     = left_r;
  assign right    = right_r;
  assign pkt_done = pkt_done_r;
  assign sync_err = sync_err_r;

endmodule
